bbox_extractor: RTL and testbench

- Per-frame bounding-box extractor for the human-detection path.
- Consumes a binary foreground stream produced by the upstream skin/motion mask stage, in the same vsync/href/clken timing as the video stream.
- Accumulates the min/max column and row of foreground pixels over each frame, plus a foreground pixel count.
- At each frame end it publishes rectangular_up/down/left/right and flag to the rectangle-overlay stage directly downstream. Values are held stable for the whole next frame.

---
 rtl/bbox_pkg.sv | 37 +++
 rtl/frame_xy_counter.sv | 37 +++
 rtl/bbox_extractor.sv | 100 ++++++++++
 tb/tb_bbox_extractor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbox_pkg.sv
// Shared widths, default image geometry and the accumulator empty state
// for the bounding-box extraction path.
package bbox_pkg;

  localparam int COORD_W = 11;
  localparam int CNT_W   = 20;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  localparam coord_t COORD_ONE     = 11'd1;
  localparam coord_t IMG_HDISP_DEF = 11'd1024;
  localparam coord_t IMG_VDISP_DEF = 11'd768;

  localparam coord_t X_MIN_INIT_DEF = IMG_HDISP_DEF - COORD_ONE;
  localparam coord_t Y_MIN_INIT_DEF = IMG_VDISP_DEF - COORD_ONE;

  typedef struct packed {
    coord_t x_min;
    coord_t x_max;
    coord_t y_min;
    coord_t y_max;
    cnt_t   cnt;
  } acc_t;

  // min fields start at the far edge so the first foreground pixel always wins
  function automatic acc_t acc_empty(input coord_t hdisp, input coord_t vdisp);
    acc_t a;
    a.x_min = hdisp - COORD_ONE;
    a.x_max = '0;
    a.y_min = vdisp - COORD_ONE;
    a.y_max = '0;
    a.cnt   = '0;
    return a;
  endfunction

endpackage

// File: rtl/frame_xy_counter.sv
// Pixel column/row generator driven by vsync and the pixel strobe; shares
// its counting rules with the overlay stage so coordinates line up.
module frame_xy_counter
  import bbox_pkg::*;
#(
  parameter coord_t IMG_HDISP = IMG_HDISP_DEF,
  parameter coord_t IMG_VDISP = IMG_VDISP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               per_frame_vsync,
  input  logic               per_frame_clken,
  output logic [COORD_W-1:0] x_cnt,
  output logic [COORD_W-1:0] y_cnt
);

  localparam coord_t X_LAST = IMG_HDISP - COORD_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (per_frame_vsync) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (per_frame_clken) begin
      if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        // row counter parks at IMG_VDISP so trailing strobes never alias row 0
        if (y_cnt < IMG_VDISP) y_cnt <= y_cnt + COORD_ONE;
      end else begin
        x_cnt <= x_cnt + COORD_ONE;
      end
    end
  end

endmodule

// File: rtl/bbox_extractor.sv
// Per-frame bounding box of foreground pixels with margin and clamping;
// results publish on the vsync rising edge and hold for the next frame.
module bbox_extractor
  import bbox_pkg::*;
#(
  parameter coord_t IMG_HDISP  = IMG_HDISP_DEF,
  parameter coord_t IMG_VDISP  = IMG_VDISP_DEF,
  parameter cnt_t   MIN_PIXELS = 20'd256,
  parameter coord_t MARGIN     = 11'd4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               per_frame_vsync,
  input  logic               per_frame_href,
  input  logic               per_frame_clken,
  input  logic               per_img_bit,
  output logic [COORD_W-1:0] rectangular_up,
  output logic [COORD_W-1:0] rectangular_down,
  output logic [COORD_W-1:0] rectangular_left,
  output logic [COORD_W-1:0] rectangular_right,
  output logic               flag,
  output logic               frame_done,
  output logic [CNT_W-1:0]   pix_count
);

  localparam coord_t X_LAST    = IMG_HDISP - COORD_ONE;
  localparam coord_t Y_LAST    = IMG_VDISP - COORD_ONE;
  localparam acc_t   ACC_EMPTY = acc_empty(IMG_HDISP, IMG_VDISP);
  localparam cnt_t   CNT_ONE   = 20'd1;

  coord_t x_cnt, y_cnt;
  acc_t   acc;
  logic   vs_d;
  logic   fe;
  logic   acc_en;
  logic   box_valid;

  logic [COORD_W:0] x_hi_sum, y_hi_sum;
  coord_t           left_nxt, right_nxt, up_nxt, down_nxt;

  frame_xy_counter #(
    .IMG_HDISP(IMG_HDISP),
    .IMG_VDISP(IMG_VDISP)
  ) u_xy (
    .clk            (clk),
    .rst_n          (rst_n),
    .per_frame_vsync(per_frame_vsync),
    .per_frame_clken(per_frame_clken),
    .x_cnt          (x_cnt),
    .y_cnt          (y_cnt)
  );

  assign fe        = per_frame_vsync & ~vs_d;
  assign acc_en    = ~per_frame_vsync & per_frame_clken & per_frame_href & per_img_bit
                     & (y_cnt < IMG_VDISP);
  assign box_valid = (acc.cnt >= MIN_PIXELS);

  // one extra bit on the high-side sums keeps max+MARGIN from wrapping
  assign x_hi_sum  = {1'b0, acc.x_max} + {1'b0, MARGIN};
  assign y_hi_sum  = {1'b0, acc.y_max} + {1'b0, MARGIN};
  assign left_nxt  = (acc.x_min > MARGIN) ? acc.x_min - MARGIN : '0;
  assign up_nxt    = (acc.y_min > MARGIN) ? acc.y_min - MARGIN : '0;
  assign right_nxt = (x_hi_sum > {1'b0, X_LAST}) ? X_LAST : x_hi_sum[COORD_W-1:0];
  assign down_nxt  = (y_hi_sum > {1'b0, Y_LAST}) ? Y_LAST : y_hi_sum[COORD_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d              <= 1'b0;
      acc               <= ACC_EMPTY;
      rectangular_up    <= '0;
      rectangular_down  <= '0;
      rectangular_left  <= '0;
      rectangular_right <= '0;
      flag              <= 1'b0;
      frame_done        <= 1'b0;
      pix_count         <= '0;
    end else begin
      vs_d       <= per_frame_vsync;
      frame_done <= fe;
      if (fe) begin
        pix_count <= acc.cnt;
        flag      <= box_valid;
        if (box_valid) begin
          rectangular_up    <= up_nxt;
          rectangular_down  <= down_nxt;
          rectangular_left  <= left_nxt;
          rectangular_right <= right_nxt;
        end
        acc <= ACC_EMPTY;
      end else if (acc_en) begin
        if (x_cnt < acc.x_min) acc.x_min <= x_cnt;
        if (x_cnt > acc.x_max) acc.x_max <= x_cnt;
        if (y_cnt < acc.y_min) acc.y_min <= y_cnt;
        if (y_cnt > acc.y_max) acc.y_max <= y_cnt;
        if (acc.cnt != {CNT_W{1'b1}}) acc.cnt <= acc.cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_bbox_extractor.sv
// Directed bench for bbox_extractor on a 32x16 image with hand-computed boxes.
module tb_bbox_extractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit;
  logic [10:0] rectangular_up, rectangular_down, rectangular_left, rectangular_right;
  logic        flag, frame_done;
  logic [19:0] pix_count;

  int errors = 0;
  int checks = 0;

  logic mask [0:15][0:31];

  bbox_extractor #(
    .IMG_HDISP (11'd32),
    .IMG_VDISP (11'd16),
    .MIN_PIXELS(20'd4),
    .MARGIN    (11'd2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_bit      (per_img_bit),
    .rectangular_up   (rectangular_up),
    .rectangular_down (rectangular_down),
    .rectangular_left (rectangular_left),
    .rectangular_right(rectangular_right),
    .flag             (flag),
    .frame_done       (frame_done),
    .pix_count        (pix_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic clear_mask();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 32; x++) mask[y][x] = 1'b0;
  endtask

  // mode 0: normal, mode 1: href held low, mode 2: clken held low
  task automatic run_frame(input int mode, input int lines);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < 32; x++) begin
        @(negedge clk);
        per_frame_href  = (mode != 1);
        per_frame_clken = (mode != 2);
        per_img_bit     = mask[y][x];
      end
      @(negedge clk);
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      per_img_bit     = 1'b0;
    end
  endtask

  // raise vsync and return at the first negedge after the fe edge
  task automatic raise_vsync();
    @(negedge clk);
    per_frame_vsync = 1'b1;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_bit     = 1'b0;
    @(negedge clk);
  endtask

  // one negedge later: pulse must be gone; vsync drops for the next frame
  task automatic close_vsync(input string name);
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s frame_done_width: got %b, want 0", name, frame_done);
    end
    per_frame_vsync = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    per_frame_vsync = 1'b1;
    per_frame_href = 1'b0;
    per_frame_clken = 1'b0;
    per_img_bit = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rectangular_up, rectangular_down, rectangular_left, rectangular_right,
         flag, frame_done, pix_count} !== 65'd0) begin
      errors++;
      $display("FAIL reset_outputs: got up=%0d down=%0d left=%0d right=%0d flag=%b done=%b cnt=%0d, want all 0",
               rectangular_up, rectangular_down, rectangular_left, rectangular_right,
               flag, frame_done, pix_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({frame_done, flag, pix_count} !== {1'b1, 1'b0, 20'd0}) begin
      errors++;
      $display("FAIL release_fe: got done=%b flag=%b cnt=%0d, want done=1 flag=0 cnt=0",
               frame_done, flag, pix_count);
    end
    close_vsync("release");
  endtask

  task automatic test_filled_block();
    clear_mask();
    for (int y = 5; y <= 7; y++)
      for (int x = 10; x <= 13; x++) mask[y][x] = 1'b1;
    run_frame(0, 16);
    raise_vsync();
    checks++;
    if ({rectangular_up, rectangular_down, rectangular_left, rectangular_right} !==
        {11'd3, 11'd9, 11'd8, 11'd15}) begin
      errors++;
      $display("FAIL block_rect: got %0d/%0d/%0d/%0d, want 3/9/8/15",
               rectangular_up, rectangular_down, rectangular_left, rectangular_right);
    end
    checks++;
    if ({flag, frame_done, pix_count} !== {1'b1, 1'b1, 20'd12}) begin
      errors++;
      $display("FAIL block_status: got flag=%b done=%b cnt=%0d, want 1 1 12",
               flag, frame_done, pix_count);
    end
    close_vsync("block");
  endtask

  task automatic test_below_threshold();
    clear_mask();
    mask[1][1] = 1'b1;
    mask[1][2] = 1'b1;
    mask[1][3] = 1'b1;
    run_frame(0, 16);
    raise_vsync();
    checks++;
    if ({rectangular_up, rectangular_down, rectangular_left, rectangular_right} !==
        {11'd3, 11'd9, 11'd8, 11'd15}) begin
      errors++;
      $display("FAIL below_rect_hold: got %0d/%0d/%0d/%0d, want 3/9/8/15",
               rectangular_up, rectangular_down, rectangular_left, rectangular_right);
    end
    checks++;
    if ({flag, frame_done, pix_count} !== {1'b0, 1'b1, 20'd3}) begin
      errors++;
      $display("FAIL below_status: got flag=%b done=%b cnt=%0d, want 0 1 3",
               flag, frame_done, pix_count);
    end
    close_vsync("below");
  endtask

  task automatic test_clamping();
    clear_mask();
    mask[0][0]   = 1'b1;
    mask[0][1]   = 1'b1;
    mask[15][31] = 1'b1;
    mask[15][30] = 1'b1;
    run_frame(0, 16);
    raise_vsync();
    checks++;
    if ({rectangular_up, rectangular_down, rectangular_left, rectangular_right} !==
        {11'd0, 11'd15, 11'd0, 11'd31}) begin
      errors++;
      $display("FAIL clamp_rect: got %0d/%0d/%0d/%0d, want 0/15/0/31",
               rectangular_up, rectangular_down, rectangular_left, rectangular_right);
    end
    checks++;
    if ({flag, frame_done, pix_count} !== {1'b1, 1'b1, 20'd4}) begin
      errors++;
      $display("FAIL clamp_status: got flag=%b done=%b cnt=%0d, want 1 1 4",
               flag, frame_done, pix_count);
    end
  endtask

  // continues the vsync hold left by test_clamping
  task automatic test_gating();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      per_frame_href  = 1'b1;
      per_frame_clken = 1'b1;
      per_img_bit     = 1'b1;
    end
    @(negedge clk);
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_bit     = 1'b0;
    per_frame_vsync = 1'b0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 32; x++) mask[y][x] = 1'b1;
    run_frame(1, 16);
    run_frame(2, 16);
    raise_vsync();
    checks++;
    if ({flag, frame_done, pix_count} !== {1'b0, 1'b1, 20'd0}) begin
      errors++;
      $display("FAIL gate_status: got flag=%b done=%b cnt=%0d, want 0 1 0",
               flag, frame_done, pix_count);
    end
    checks++;
    if ({rectangular_up, rectangular_down, rectangular_left, rectangular_right} !==
        {11'd0, 11'd15, 11'd0, 11'd31}) begin
      errors++;
      $display("FAIL gate_rect_hold: got %0d/%0d/%0d/%0d, want 0/15/0/31",
               rectangular_up, rectangular_down, rectangular_left, rectangular_right);
    end
    close_vsync("gate");
  endtask

  task automatic test_reset_mid_frame();
    clear_mask();
    for (int x = 0; x < 10; x++) mask[0][x] = 1'b1;
    run_frame(0, 2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({rectangular_up, rectangular_down, rectangular_left, rectangular_right,
         flag, frame_done, pix_count} !== 65'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got up=%0d down=%0d left=%0d right=%0d flag=%b cnt=%0d, want all 0",
               rectangular_up, rectangular_down, rectangular_left, rectangular_right,
               flag, pix_count);
    end
    rst_n = 1'b1;
    clear_mask();
    for (int x = 20; x <= 24; x++) mask[2][x] = 1'b1;
    run_frame(0, 16);
    raise_vsync();
    checks++;
    if ({rectangular_up, rectangular_down, rectangular_left, rectangular_right} !==
        {11'd0, 11'd4, 11'd18, 11'd26}) begin
      errors++;
      $display("FAIL midrst_rect: got %0d/%0d/%0d/%0d, want 0/4/18/26",
               rectangular_up, rectangular_down, rectangular_left, rectangular_right);
    end
    checks++;
    if ({flag, frame_done, pix_count} !== {1'b1, 1'b1, 20'd5}) begin
      errors++;
      $display("FAIL midrst_status: got flag=%b done=%b cnt=%0d, want 1 1 5",
               flag, frame_done, pix_count);
    end
    close_vsync("midrst");
  endtask

  task automatic test_long_vsync();
    int pulses = 0;
    int unstable = 0;
    clear_mask();
    for (int x = 6; x <= 9; x++) mask[4][x] = 1'b1;
    run_frame(0, 16);
    @(negedge clk);
    per_frame_vsync = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) pulses++;
      if ({rectangular_up, rectangular_down, rectangular_left, rectangular_right, flag, pix_count}
          !== {11'd2, 11'd6, 11'd4, 11'd11, 1'b1, 20'd4}) unstable++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL long_vsync_pulses: got %0d frame_done pulses, want 1", pulses);
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL long_vsync_hold: outputs off 2/6/4/11 flag=1 cnt=4 in %0d of 100 cycles, want 0 (now %0d/%0d/%0d/%0d %b %0d)",
               unstable, rectangular_up, rectangular_down, rectangular_left,
               rectangular_right, flag, pix_count);
    end
    per_frame_vsync = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL long_vsync_fall: got frame_done=%b after vsync fall, want 0", frame_done);
    end
  endtask

  initial begin
    test_reset();
    test_filled_block();
    test_below_threshold();
    test_clamping();
    test_gating();
    test_reset_mid_frame();
    test_long_vsync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
